// File: rtl/md_integrator.sv
// Leapfrog integrator: buffers one timestep of forces, then sweeps every atom once (v += f, p += v).
// Optional net-force monitor enabled with `define MD_NETFORCE_CHECK_EN.
module md_integrator #(
  parameter int N_ATOMS  = 32,
  parameter int AW       = 6,
  parameter int FW       = 16,
  parameter int VW       = 16,
  parameter int PW       = 16,
  parameter int DT_SHIFT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_we,
  input  logic [AW-1:0] in_addr,
  input  logic [FW-1:0] in_fx,
  input  logic [FW-1:0] in_fy,
  input  logic [FW-1:0] in_fz,
  input  logic          in_done,
  input  logic          init_we,
  input  logic [AW-1:0] init_addr,
  input  logic [PW-1:0] init_px,
  input  logic [PW-1:0] init_py,
  input  logic [PW-1:0] init_pz,
  input  logic [AW-1:0] rd_addr,
  output logic [PW-1:0] rd_px,
  output logic [PW-1:0] rd_py,
  output logic [PW-1:0] rd_pz,
  output logic          busy,
  output logic          step_done,
  output logic          err,
  output logic          net_nz
);

  localparam int IW   = (N_ATOMS > 1) ? $clog2(N_ATOMS) : 1;
  localparam int FMAX = 2 ** (FW - 1) - 1;
  localparam int FMIN = -(2 ** (FW - 1));
  localparam int VMAX = 2 ** (VW - 1) - 1;
  localparam int VMIN = -(2 ** (VW - 1));

  typedef enum logic [1:0] {IDLE, COLLECT, UPDATE, FINISH} state_t;

  state_t        state, state_next;
  logic [IW-1:0] cnt;
  logic          err_reg;

  logic [FW-1:0] frc [3][N_ATOMS];
  logic [VW-1:0] vel [3][N_ATOMS];
  logic [PW-1:0] pos [3][N_ATOMS];

  logic [FW-1:0] in_f   [3];
  logic [PW-1:0] init_p [3];
  logic [VW-1:0] upd_v  [3];
  logic [PW-1:0] upd_p  [3];

  logic          in_range, init_range, rd_range;
  logic          collecting, fw_ok, init_ok, go_update, last;
  logic [IW-1:0] in_idx, init_idx, rd_idx;

  function automatic logic [FW-1:0] sat_add(input logic [FW-1:0] a, input logic [FW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > FMAX) s = FMAX;
    else if (s < FMIN) s = FMIN;
    return s[FW-1:0];
  endfunction

  function automatic logic [VW-1:0] vel_next(input logic [VW-1:0] v, input logic [FW-1:0] f);
    int s;
    s = int'($signed(v)) + (int'($signed(f)) >>> DT_SHIFT);
    if (s > VMAX) s = VMAX;
    else if (s < VMIN) s = VMIN;
    return s[VW-1:0];
  endfunction

  // Periodic box: plain modular add, no clamp.
  function automatic logic [PW-1:0] pos_next(input logic [PW-1:0] p, input logic [VW-1:0] v);
    logic signed [VW-1:0] dv;
    dv = $signed(v) >>> DT_SHIFT;
    return p + PW'(dv);
  endfunction

  assign in_range   = {1'b0, in_addr}   < (AW+1)'(N_ATOMS);
  assign init_range = {1'b0, init_addr} < (AW+1)'(N_ATOMS);
  assign rd_range   = {1'b0, rd_addr}   < (AW+1)'(N_ATOMS);
  assign in_idx     = in_addr[IW-1:0];
  assign init_idx   = init_addr[IW-1:0];
  assign rd_idx     = rd_addr[IW-1:0];

  assign collecting = (state == IDLE) || (state == COLLECT);
  assign fw_ok      = in_we && in_range && collecting;
  assign init_ok    = init_we && init_range && (state == IDLE);
  assign go_update  = in_done && collecting;
  assign last       = (cnt == IW'(N_ATOMS - 1));

  always_comb begin
    in_f[0]   = in_fx;
    in_f[1]   = in_fy;
    in_f[2]   = in_fz;
    init_p[0] = init_px;
    init_p[1] = init_py;
    init_p[2] = init_pz;
    for (int k = 0; k < 3; k++) begin
      upd_v[k] = vel_next(vel[k][cnt], frc[k][cnt]);
      upd_p[k] = pos_next(pos[k][cnt], upd_v[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go_update) state_next = UPDATE;
               else if (fw_ok) state_next = COLLECT;
      COLLECT: if (in_done) state_next = UPDATE;
      UPDATE:  if (last) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == UPDATE) || (state == FINISH);
    step_done = (state == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt <= (state == UPDATE) ? cnt + 1'b1 : '0;
      if (in_we && (!collecting || !in_range)) err_reg <= 1'b1;
    end
  end
  assign err = err_reg;

  // Force slot i is consumed and cleared in the same sweep cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < N_ATOMS; i++) begin
          frc[k][i] <= '0;
          vel[k][i] <= '0;
          pos[k][i] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (state == UPDATE) begin
          vel[k][cnt] <= upd_v[k];
          pos[k][cnt] <= upd_p[k];
          frc[k][cnt] <= '0;
        end
        if (fw_ok) frc[k][in_idx] <= sat_add(frc[k][in_idx], in_f[k]);
        if (init_ok) begin
          pos[k][init_idx] <= init_p[k];
          vel[k][init_idx] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_px <= '0;
      rd_py <= '0;
      rd_pz <= '0;
    end else begin
      rd_px <= rd_range ? pos[0][rd_idx] : '0;
      rd_py <= rd_range ? pos[1][rd_idx] : '0;
      rd_pz <= rd_range ? pos[2][rd_idx] : '0;
    end
  end

`ifdef MD_NETFORCE_CHECK_EN
  localparam int NW = FW + AW + 1;
  logic [NW-1:0] net_sum [3];
  logic [NW-1:0] net_add [3];
  logic          net_any, net_pend, net_nz_reg;

  always_comb begin
    net_any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      net_add[k] = net_sum[k] + (fw_ok ? NW'($signed(in_f[k])) : {NW{1'b0}});
      net_any    = net_any | (net_add[k] != {NW{1'b0}});
    end
  end

  // The verdict is captured as the sweep starts, published with step_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) net_sum[k] <= '0;
      net_pend   <= 1'b0;
      net_nz_reg <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) net_sum[k] <= go_update ? {NW{1'b0}} : net_add[k];
      if (go_update) net_pend <= net_any;
      if (state == UPDATE && last) net_nz_reg <= net_pend;
    end
  end
  assign net_nz = net_nz_reg;
`else
  assign net_nz = 1'b0;
`endif

endmodule

// File: tb/tb_md_integrator.sv
// Randomized self-checking bench for md_integrator against a whole-step behavioural model.
module tb_md_integrator;
  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_we, in_done, init_we;
  logic [5:0]  in_addr, init_addr, rd_addr;
  logic [15:0] in_fx, in_fy, in_fz, init_px, init_py, init_pz;
  logic [15:0] rd_px, rd_py, rd_pz;
  logic        busy, step_done, err, net_nz;

  int vectors = 0;
  int miscompares = 0;

  int mpos [3][N];
  int mvel [3][N];
  int mfrc [3][N];
  int msum [3];
  bit mcollect;
  bit mnet;

  md_integrator dut (
    .clk(clk), .rst_n(rst_n),
    .in_we(in_we), .in_addr(in_addr), .in_fx(in_fx), .in_fy(in_fy), .in_fz(in_fz),
    .in_done(in_done),
    .init_we(init_we), .init_addr(init_addr),
    .init_px(init_px), .init_py(init_py), .init_pz(init_pz),
    .rd_addr(rd_addr), .rd_px(rd_px), .rd_py(rd_py), .rd_pz(rd_pz),
    .busy(busy), .step_done(step_done), .err(err), .net_nz(net_nz)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x, input int bits);
    int hi, lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic int wrap16(input int x);
    logic [15:0] t;
    t = x[15:0];
    return int'($signed(t));
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        mpos[k][i] = 0; mvel[k][i] = 0; mfrc[k][i] = 0;
      end
      msum[k] = 0;
    end
    mcollect = 0;
    mnet = 0;
  endtask

  task automatic model_force(input int a, input int fx, input int fy, input int fz);
    int f [3];
    f[0] = fx; f[1] = fy; f[2] = fz;
    if (a < N) begin
      for (int k = 0; k < 3; k++) begin
        mfrc[k][a] = sat(mfrc[k][a] + f[k], 16);
        msum[k] += f[k];
      end
      mcollect = 1;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 3; k++) begin
        mvel[k][i] = sat(mvel[k][i] + (mfrc[k][i] >>> 4), 16);
        mpos[k][i] = wrap16(mpos[k][i] + (mvel[k][i] >>> 4));
        mfrc[k][i] = 0;
      end
    end
    mnet = (msum[0] != 0) || (msum[1] != 0) || (msum[2] != 0);
    for (int k = 0; k < 3; k++) msum[k] = 0;
    mcollect = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_we = 0; in_done = 0; init_we = 0;
    repeat (2) @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic apply_force(input int a, input int fx, input int fy, input int fz);
    @(negedge clk);
    in_we = 1; in_addr = 6'(a); in_fx = 16'(fx); in_fy = 16'(fy); in_fz = 16'(fz);
    @(negedge clk);
    in_we = 0;
    model_force(a, fx, fy, fz);
  endtask

  task automatic init_atom(input int a, input int px, input int py, input int pz);
    @(negedge clk);
    init_we = 1; init_addr = 6'(a); init_px = 16'(px); init_py = 16'(py); init_pz = 16'(pz);
    @(negedge clk);
    init_we = 0;
    if (a < N && !mcollect) begin
      mpos[0][a] = wrap16(px); mpos[1][a] = wrap16(py); mpos[2][a] = wrap16(pz);
      for (int k = 0; k < 3; k++) mvel[k][a] = 0;
    end
  endtask

  task automatic read_pos(input int a, output logic [47:0] got);
    @(negedge clk);
    rd_addr = 6'(a);
    @(negedge clk);
    got = {rd_px, rd_py, rd_pz};
  endtask

  function automatic logic [47:0] model_pos(input int a);
    if (a >= N) return 48'd0;
    return {16'(mpos[0][a]), 16'(mpos[1][a]), 16'(mpos[2][a])};
  endfunction

  // One sweep: pulses in_done (optionally with a same-cycle write), measures latency and busy.
  task automatic run_step(input bit wr, input int a, input int fx, input int fy, input int fz,
                          input bit inject);
    int cyc;
    bit busy_ok;
    bit exp_net;
    @(negedge clk);
    in_done = 1;
    if (wr) begin
      in_we = 1; in_addr = 6'(a); in_fx = 16'(fx); in_fy = 16'(fy); in_fz = 16'(fz);
    end
    @(negedge clk);
    in_done = 0;
    in_we = 0;
    if (wr) model_force(a, fx, fy, fz);
    cyc = 1;
    busy_ok = 1;
    while (step_done !== 1'b1 && cyc < 100) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (inject && cyc == 10) begin
        in_we = 1; in_addr = 6'd4; in_fx = 16'd1000; in_fy = 16'd1000; in_fz = 16'd1000;
      end else begin
        in_we = 0;
      end
      @(negedge clk);
      cyc++;
    end
    in_we = 0;
    vectors++;
    if (cyc != 33) begin
      miscompares++;
      $display("FAIL step_latency: got %0d cycles, expected 33", cyc);
    end
    vectors++;
    if (!busy_ok || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_during_sweep: busy_ok=%0d busy=%b, expected busy high throughout", busy_ok, busy);
    end
    model_step();
`ifdef MD_NETFORCE_CHECK_EN
    exp_net = mnet;
`else
    exp_net = 1'b0;
`endif
    vectors++;
    if (net_nz !== exp_net) begin
      miscompares++;
      $display("FAIL net_nz_at_done: got %b, expected %b", net_nz, exp_net);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || step_done !== 1'b0) begin
      miscompares++;
      $display("FAIL after_step: busy=%b step_done=%b, expected 0 0", busy, step_done);
    end
    $display("step: latency=%0d cycles net_nz=%b err=%b", cyc, net_nz, err);
  endtask

  task automatic test_reset();
    logic [47:0] got;
    do_reset();
    vectors++;
    if ({busy, step_done, err, net_nz} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/step_done/err/net_nz=%b, expected 0000",
               {busy, step_done, err, net_nz});
    end
    read_pos(5, got);
    vectors++;
    if (got !== 48'd0) begin
      miscompares++;
      $display("FAIL reset_read5: got %h, expected 0", got);
    end
    $display("reset: flags=%b rd5=%h", {busy, step_done, err, net_nz}, got);
  endtask

  task automatic test_basic();
    logic [47:0] got;
    do_reset();
    init_atom(3, 100, 0, 0);
    apply_force(3, 512, 0, 0);
    run_step(0, 0, 0, 0, 0, 0);
    read_pos(3, got);
    vectors++;
    if (got !== {16'd102, 16'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL basic_pos3: got %h, expected px=102 py=0 pz=0", got);
    end
    $display("basic: atom3 pos=%h", got);
  endtask

  task automatic test_netforce();
    do_reset();
    apply_force(0, 64, 0, 0);
    apply_force(1, -64, 0, 0);
    run_step(0, 0, 0, 0, 0, 0);
    apply_force(0, 64, 0, 0);
    apply_force(1, -32, 0, 0);
    run_step(0, 0, 0, 0, 0, 0);
`ifdef MD_NETFORCE_CHECK_EN
    vectors++;
    if (net_nz !== 1'b1) begin
      miscompares++;
      $display("FAIL netforce_unbalanced: got %b, expected 1", net_nz);
    end
`endif
    $display("netforce: net_nz=%b", net_nz);
  endtask

  task automatic test_saturation();
    logic [47:0] got;
    do_reset();
    for (int s = 1; s <= 17; s++) begin
      apply_force(7, 32767, 0, 0);
      run_step(0, 0, 0, 0, 0, 0);
      read_pos(7, got);
      vectors++;
      if (got !== model_pos(7)) begin
        miscompares++;
        $display("FAIL sat_step%0d_pos7: got %h, expected %h", s, got, model_pos(7));
      end
      $display("saturation: step %0d atom7 pos=%h", s, got);
    end
  endtask

  task automatic test_wrap();
    logic [47:0] got;
    do_reset();
    init_atom(2, 32760, 0, 0);
    apply_force(2, 2048, 0, 0);
    run_step(0, 0, 0, 0, 0, 0);
    read_pos(2, got);
    vectors++;
    if (got !== {16'h8000, 16'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL wrap_pos2: got %h, expected 8000_0000_0000", got);
    end
    $display("wrap: atom2 pos=%h", got);
  endtask

  task automatic test_back_to_back();
    logic [47:0] got;
    do_reset();
    apply_force(9, 800, -800, 160);
    run_step(1, 9, 800, -800, 160, 0);
    read_pos(9, got);
    vectors++;
    if (got !== model_pos(9)) begin
      miscompares++;
      $display("FAIL b2b_pos9: got %h, expected %h", got, model_pos(9));
    end
    run_step(1, 10, -4000, 3000, 0, 0);
    read_pos(10, got);
    vectors++;
    if (got !== model_pos(10)) begin
      miscompares++;
      $display("FAIL b2b_idle_pos10: got %h, expected %h", got, model_pos(10));
    end
    $display("back_to_back: atom9=%h atom10=%h", model_pos(9), got);
  endtask

  task automatic test_random();
    logic [47:0] got;
    do_reset();
    for (int i = 0; i < 8; i++) init_atom($urandom_range(0, N - 1), rnd16(), rnd16(), rnd16());
    for (int s = 0; s < 3; s++) begin
      for (int w = 0; w < 12; w++) begin
        apply_force($urandom_range(0, N - 1), rnd16(), rnd16(), rnd16());
        if (w == 3) init_atom($urandom_range(0, N - 1), rnd16(), rnd16(), rnd16());
      end
      apply_force(5, 30000, -30000, 12345);
      apply_force(5, 30000, -30000, 12345);
      run_step(0, 0, 0, 0, 0, 0);
      for (int a = 0; a < N; a++) begin
        read_pos(a, got);
        vectors++;
        if (got !== model_pos(a)) begin
          miscompares++;
          $display("FAIL random_s%0d_pos%0d: got %h, expected %h", s, a, got, model_pos(a));
        end
      end
      $display("random: step %0d atoms checked, atom5=%h", s, model_pos(5));
    end
    read_pos(40, got);
    vectors++;
    if (got !== 48'd0) begin
      miscompares++;
      $display("FAIL read_out_of_range: got %h, expected 0", got);
    end
    init_atom(45, 1, 2, 3);
    run_step(0, 0, 0, 0, 0, 0);
    read_pos(13, got);
    vectors++;
    if (got !== model_pos(13)) begin
      miscompares++;
      $display("FAIL random_coast_pos13: got %h, expected %h", got, model_pos(13));
    end
    $display("random: out-of-range read=%h", 48'd0);
  endtask

  task automatic test_errors();
    logic [47:0] got;
    do_reset();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_after_reset: got %b, expected 0", err);
    end
    run_step(0, 0, 0, 0, 0, 1);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_busy_write: got %b, expected 1", err);
    end
    run_step(0, 0, 0, 0, 0, 0);
    read_pos(4, got);
    vectors++;
    if (got !== model_pos(4)) begin
      miscompares++;
      $display("FAIL busy_write_dropped_pos4: got %h, expected %h", got, model_pos(4));
    end
    do_reset();
    apply_force(40, 500, 500, 500);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_bad_addr: err=%b busy=%b, expected 1 0", err, busy);
    end
    run_step(0, 0, 0, 0, 0, 0);
    repeat (20) @(negedge clk);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, expected 1", err);
    end
    do_reset();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_cleared_by_reset: got %b, expected 0", err);
    end
    $display("errors: err sticky then cleared");
  endtask

  task automatic test_reset_mid_sweep();
    logic [47:0] got;
    do_reset();
    init_atom(6, 1000, 2000, 3000);
    apply_force(6, 4000, 4000, 4000);
    @(negedge clk);
    in_done = 1;
    @(negedge clk);
    in_done = 0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || step_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midsweep_async_reset: busy=%b step_done=%b, expected 0 0", busy, step_done);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    read_pos(6, got);
    vectors++;
    if (got !== 48'd0) begin
      miscompares++;
      $display("FAIL midsweep_pos6: got %h, expected 0", got);
    end
    $display("reset_mid_sweep: atom6 pos=%h", got);
  endtask

  initial begin
    rst_n = 1'b0;
    in_we = 0; in_done = 0; init_we = 0;
    in_addr = 0; init_addr = 0; rd_addr = 0;
    in_fx = 0; in_fy = 0; in_fz = 0;
    init_px = 0; init_py = 0; init_pz = 0;
    model_clear();
    test_reset();
    test_basic();
    test_netforce();
    test_saturation();
    test_wrap();
    test_back_to_back();
    test_random();
    test_errors();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_integrator.md
Name: md_integrator

Overview:
- Downstream of md_kernel: consumes its per-atom force write stream (out_we/out_addr/out_fx/fy/fz) and its done pulse.
- Buffers one timestep of forces, then sweeps all atoms once with a fixed-point leapfrog update: velocity += force, position += velocity, in a periodic box.
- Holds the authoritative position/velocity state. Provides an init write port and a position read port for the rest of the pipeline.

Parameters:
N_ATOMS, 32, number of atoms, indices 0..N_ATOMS-1
AW, 6, atom index width
FW, 16, signed force component width
VW, 16, signed velocity width
PW, 16, signed position width; box wraps modulo 2^PW
DT_SHIFT, 4, arithmetic right shift applied for both the force->velocity and velocity->position steps

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_we  in  1  force write strobe (from md_kernel out_we)
in_addr  in  AW  atom index of the force write
in_fx, in_fy, in_fz  in  FW each  signed force components
in_done  in  1  end-of-force-stream pulse (from md_kernel done)
init_we  in  1  position init write; the same write zeroes that atom's velocity
init_addr  in  AW  atom index for init
init_px, init_py, init_pz  in  PW each  initial position
rd_addr  in  AW  position read index
rd_px, rd_py, rd_pz  out  PW each  registered read data, 1-cycle latency
busy  out  1  update sweep in progress
step_done  out  1  one-cycle pulse when the sweep completes
err  out  1  sticky error flag: overrun or out-of-range index
net_nz  out  1  net-force-nonzero flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - All position, velocity and force-buffer entries = 0.
  - State = IDLE.
  - busy, step_done, err, net_nz = 0; rd_* = 0.
- States: IDLE, COLLECT, UPDATE, FINISH.
- IDLE:
  - in_we -> accept the write, go to COLLECT.
  - init_we -> write that atom's position and zero its velocity.
  - in_done with no prior writes -> go to UPDATE; all forces are 0.
- COLLECT:
  - Each in_we adds fx/fy/fz into the buffer for in_addr with saturating add.
  - Repeated writes to the same atom accumulate.
  - init_we is ignored in this state.
- in_we and in_done in the same cycle: the write is accepted first, then transition to UPDATE.
- UPDATE:
  - Counter i runs 0..N_ATOMS-1, one atom per cycle.
  - v' = sat_VW(v + (f >>> DT_SHIFT)).
  - p' = p + (v' >>> DT_SHIFT), wrapping modulo 2^PW (periodic box, no saturation).
  - f[i] is cleared to 0 in the same cycle it is consumed.
- FINISH: step_done = 1 for one cycle, then return to IDLE.
- Timing: if in_done is sampled at edge t:
  - busy = 1 from cycle t+1 through the step_done cycle inclusive.
  - step_done is high during cycle t+N_ATOMS+1.
- While busy:
  - in_we -> write dropped, err set.
  - in_done -> ignored.
  - init_we -> ignored.
- in_addr >= N_ATOMS -> write dropped, err set. init_addr >= N_ATOMS -> write ignored.
- err clears only on reset.
- Read port:
  - rd_* returns the entry at rd_addr sampled on the previous edge.
  - Data is guaranteed coherent only when busy = 0. rd_addr >= N_ATOMS returns 0.
- Saturation: VW-bit signed clamp to [-2^(VW-1), 2^(VW-1)-1]. Force accumulation uses the same clamp at FW bits.
- Reset asserted mid-sweep: immediate return to reset state; the partial step is discarded.

Optional Feature:
- Macro: MD_NETFORCE_CHECK_EN.
- With the macro defined:
  - Three accumulators of FW+AW+1 bits sum every accepted fx, fy, fz in the step.
  - At the step_done edge, net_nz is set to (any sum != 0) and held until the next step_done.
  - The accumulators clear when the sweep starts.
- Without the macro: net_nz is tied to 0 and no accumulator logic exists.

Test Plan (all with default parameters):
1. Reset then read atom 5 -> rd_px/py/pz = 0; busy = 0, step_done = 0, err = 0.
2. init atom 3 px=100; force atom 3 fx=512; pulse in_done -> vx=32, px=102; step_done exactly 33 cycles after in_done is sampled.
3. With MD_NETFORCE_CHECK_EN:
   - Atom 0 fx=+64, atom 1 fx=-64 -> net_nz=0.
   - Next step: atom 0 fx=+64, atom 1 fx=-32 -> net_nz=1.
4. Apply fx=32767 to atom 7 for 17 steps:
   - After 16 steps vx=32752.
   - After step 17 vx=32767, saturated with no wrap.
5. init atom 2 px=32760; fx=2048 -> vx=128, px wraps to -32768.
6. Error paths:
   - in_we during busy -> the write has no effect on the next step and err=1.
   - in_addr=40 in IDLE -> dropped, err=1.
   - err stays high until rst_n is asserted low.
